// File: rtl/sim_result_monitor_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sim_result_monitor_pkg                                                     |
// | Shared types, defaults and the signature-slot extraction helper for the   |
// | MIPS data-memory pass/fail monitor.                                        |
// | Ports: none (package).                                                     |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package sim_result_monitor_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int DEF_TIMEOUT = 1580;
  localparam int DEF_DRAIN   = 10;

  // Upper bounds for the generic slot helper: one slot word and one flat table.
  localparam int c_slot_w_max = 256;
  localparam int c_flat_w_max = 4096;

  // Returns slot i (w bits wide) of a flat table, zero-extended to c_slot_w_max.
  function automatic logic [c_slot_w_max-1:0] sig_slot(
    input logic [c_flat_w_max-1:0] flat,
    input int unsigned             i,
    input int unsigned             w
  );
    logic [c_slot_w_max-1:0] mask;
    // A shift by the full width yields zero, so the subtraction gives all-ones.
    mask = (c_slot_w_max'(1) << w) - c_slot_w_max'(1);
    return c_slot_w_max'(flat >> (i * w)) & mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sim_result_monitor_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sim_result_monitor_if                                                      |
// | Store bus (memwrite/dataadr/writedata) plus the programmable signature     |
// | table seen by the monitor.                                                 |
// | master: drives the bus and signature table (core / bench).                 |
// | slave : monitor side, all signals are inputs.                              |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
interface sim_result_monitor_if #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int NUM_SIG = 5
);
  logic [1:0]              memwrite;
  logic [ADDR_W-1:0]       dataadr;
  logic [DATA_W-1:0]       writedata;
  logic [NUM_SIG*ADDR_W-1:0] sig_adr;
  logic [NUM_SIG*DATA_W-1:0] sig_data;
  logic [NUM_SIG-1:0]      sig_en;

  modport master (
    output memwrite, dataadr, writedata, sig_adr, sig_data, sig_en
  );

  modport slave (
    input  memwrite, dataadr, writedata, sig_adr, sig_data, sig_en
  );
endinterface
`default_nettype wire

// File: rtl/sim_result_monitor_sig_match_pri.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sig_match_pri                                                              |
// | Combinational NUM_SIG-way (address, data) comparator with lowest-index     |
// | priority encoding.                                                         |
// | Ports: store (strobe), dataadr, writedata, sig_adr/sig_data (flat tables), |
// |        sig_en -> any_hit, hit_idx.                                         |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module sig_match_pri
  import sim_result_monitor_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int NUM_SIG = 5,
  localparam int IDX_W  = (NUM_SIG > 1) ? $clog2(NUM_SIG) : 1
) (
  input  logic                      store,
  input  logic [ADDR_W-1:0]         dataadr,
  input  logic [DATA_W-1:0]         writedata,
  input  logic [NUM_SIG*ADDR_W-1:0] sig_adr,
  input  logic [NUM_SIG*DATA_W-1:0] sig_data,
  input  logic [NUM_SIG-1:0]        sig_en,
  output logic                      any_hit,
  output logic [IDX_W-1:0]          hit_idx
);

  logic [c_flat_w_max-1:0] w_adr_flat;
  logic [c_flat_w_max-1:0] w_data_flat;
  logic [NUM_SIG-1:0]      w_match;

  assign w_adr_flat  = c_flat_w_max'(sig_adr);
  assign w_data_flat = c_flat_w_max'(sig_data);

  // Both sides are zero-extended identically, so the compare stays full width.
  for (genvar gi = 0; gi < NUM_SIG; gi++) begin : g_slot
    assign w_match[gi] = sig_en[gi] & store
                       & (sig_slot(w_adr_flat,  gi, ADDR_W) == c_slot_w_max'(dataadr))
                       & (sig_slot(w_data_flat, gi, DATA_W) == c_slot_w_max'(writedata));
  end

  // Scan from the top so the lowest matching index is the last one written.
  always_comb begin
    any_hit = 1'b0;
    hit_idx = '0;
    for (int i = NUM_SIG - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        any_hit = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sim_result_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sim_result_monitor                                                         |
// | Pass/fail monitor for the MIPS data-memory write port: signature match,   |
// | cycle/store counters, timeout watchdog and post-hit drain window.         |
// | Ports: clk, reset (async active-low), bus (store bus + signature table),   |
// |        done, pass, timeout, hit_idx, hit_cycle, cycle_count, store_count,  |
// |        busy. All outputs are registered.                                   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module sim_result_monitor
  import sim_result_monitor_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int NUM_SIG = 5,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int DRAIN   = DEF_DRAIN,
  localparam int IDX_W  = (NUM_SIG > 1) ? $clog2(NUM_SIG) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  sim_result_monitor_if.slave  bus,
  output logic                 done,
  output logic                 pass,
  output logic                 timeout,
  output logic [IDX_W-1:0]     hit_idx,
  output logic [CNT_W-1:0]     hit_cycle,
  output logic [CNT_W-1:0]     cycle_count,
  output logic [CNT_W-1:0]     store_count,
  output logic                 busy
);

  localparam logic [1:0] c_st_run   = ST_RUN;
  localparam logic [1:0] c_st_drain = ST_DRAIN;
  localparam logic [1:0] c_st_done  = ST_DONE;
  localparam int         c_drain_w  = (DRAIN < 2) ? 1 : $clog2(DRAIN + 1);

  logic [1:0]           r_state;
  logic [c_drain_w-1:0] r_drain_cnt;
  logic                 r_done;
  logic                 r_pass;
  logic                 r_timeout;
  logic [IDX_W-1:0]     r_hit_idx;
  logic [CNT_W-1:0]     r_hit_cycle;
  logic [CNT_W-1:0]     r_cycle_cnt;
  logic [CNT_W-1:0]     r_store_cnt;

  logic                 w_store;
  logic                 w_any_hit;
  logic [IDX_W-1:0]     w_hit_idx;
  logic                 w_timeout_edge;

  assign w_store        = |bus.memwrite;
  assign w_timeout_edge = (r_cycle_cnt == CNT_W'(TIMEOUT - 1));

  sig_match_pri #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .NUM_SIG (NUM_SIG)
  ) u_match (
    .store     (w_store),
    .dataadr   (bus.dataadr),
    .writedata (bus.writedata),
    .sig_adr   (bus.sig_adr),
    .sig_data  (bus.sig_data),
    .sig_en    (bus.sig_en),
    .any_hit   (w_any_hit),
    .hit_idx   (w_hit_idx)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= c_st_run;
      r_drain_cnt <= '0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_timeout   <= 1'b0;
      r_hit_idx   <= '0;
      r_hit_cycle <= '0;
      r_cycle_cnt <= '0;
      r_store_cnt <= '0;
    end else begin
      // Counters run (saturating) in RUN and DRAIN, including the edge that enters DONE.
      if (r_state != c_st_done) begin
        if (!(&r_cycle_cnt)) r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
        if (w_store && !(&r_store_cnt)) r_store_cnt <= r_store_cnt + CNT_W'(1);
      end

      case (r_state)
        c_st_run: begin
          // A hit on the timeout edge wins over the watchdog.
          if (w_any_hit) begin
            r_hit_idx   <= w_hit_idx;
            r_hit_cycle <= r_cycle_cnt;
            if (DRAIN == 0) begin
              r_done  <= 1'b1;
              r_pass  <= 1'b1;
              r_state <= c_st_done;
            end else begin
              r_drain_cnt <= c_drain_w'(DRAIN);
              r_state     <= c_st_drain;
            end
          end else if (w_timeout_edge) begin
            r_timeout <= 1'b1;
            r_done    <= 1'b1;
            r_state   <= c_st_done;
          end
        end
        c_st_drain: begin
          r_drain_cnt <= r_drain_cnt - c_drain_w'(1);
          if (r_drain_cnt == c_drain_w'(1)) begin
            r_done  <= 1'b1;
            r_pass  <= 1'b1;
            r_state <= c_st_done;
          end
        end
        default: begin
          // DONE holds until reset.
        end
      endcase
    end
  end

  assign done        = r_done;
  assign pass        = r_pass;
  assign timeout     = r_timeout;
  assign hit_idx     = r_hit_idx;
  assign hit_cycle   = r_hit_cycle;
  assign cycle_count = r_cycle_cnt;
  assign store_count = r_store_cnt;
  assign busy        = (r_state != c_st_done);

endmodule
`default_nettype wire

// File: tb/tb_sim_result_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sim_result_monitor                                                      |
// | Self-checking bench: two monitors (drain 10 and drain 0) share one store   |
// | bus; a run-level reference model predicts every output each cycle.         |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_sim_result_monitor;

  localparam int c_to = 1580;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  sim_result_monitor_if #(.ADDR_W(64), .DATA_W(64), .NUM_SIG(5)) bus ();

  logic [63:0] sa [5];
  logic [63:0] sd [5];
  logic [4:0]  en;

  for (genvar g = 0; g < 5; g++) begin : g_pack
    assign bus.sig_adr[g*64 +: 64]  = sa[g];
    assign bus.sig_data[g*64 +: 64] = sd[g];
  end
  assign bus.sig_en = en;

  logic        done0, pass0, to0, busy0, done1, pass1, to1, busy1;
  logic [2:0]  hidx0, hidx1;
  logic [31:0] hcyc0, hcyc1, cyc0, cyc1, st0, st1;

  sim_result_monitor #(.DRAIN(10)) dut0 (
    .clk(clk), .reset(reset), .bus(bus.slave),
    .done(done0), .pass(pass0), .timeout(to0), .hit_idx(hidx0),
    .hit_cycle(hcyc0), .cycle_count(cyc0), .store_count(st0), .busy(busy0)
  );

  sim_result_monitor #(.DRAIN(0)) dut1 (
    .clk(clk), .reset(reset), .bus(bus.slave),
    .done(done1), .pass(pass1), .timeout(to1), .hit_idx(hidx1),
    .hit_cycle(hcyc1), .cycle_count(cyc1), .store_count(st1), .busy(busy1)
  );

  int n_asserts = 0;
  int n_fail    = 0;

  // Run-level model: e = clock edges since reset release; fin = edge on which the
  // run finishes (hit edge + drain length, or the timeout edge), -1 while open.
  int drain_v [2];
  int e;
  int m_fin  [2];
  bit m_hit  [2];
  bit m_to   [2];
  int m_hidx [2];
  int m_hcyc [2];
  int m_cyc  [2];
  int m_st   [2];

  task automatic chk(input string tag, input int d, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[dut%0d] observed=%0h expected=%0h", tag, d, obs, exp);
    end
  endtask

  function automatic int match_idx(input logic [1:0] mw, input logic [63:0] a, input logic [63:0] dat);
    for (int i = 0; i < 5; i++)
      if (en[i] && mw != 2'b00 && a == sa[i] && dat == sd[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    e = 0;
    for (int d = 0; d < 2; d++) begin
      m_fin[d] = -1; m_hit[d] = 0; m_to[d] = 0;
      m_hidx[d] = 0; m_hcyc[d] = 0; m_cyc[d] = 0; m_st[d] = 0;
    end
  endtask

  task automatic model_edge(input logic [1:0] mw, input logic [63:0] a, input logic [63:0] dat);
    int mi;
    mi = match_idx(mw, a, dat);
    for (int d = 0; d < 2; d++) begin
      if (m_fin[d] < 0 || e <= m_fin[d]) begin
        if (m_fin[d] < 0) begin
          if (mi >= 0) begin
            m_hit[d] = 1; m_hidx[d] = mi; m_hcyc[d] = e; m_fin[d] = e + drain_v[d];
          end else if (e == c_to - 1) begin
            m_to[d] = 1; m_fin[d] = e;
          end
        end
        m_cyc[d]++;
        if (mw != 2'b00) m_st[d]++;
      end
    end
    e++;
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      logic od, op, ot, ob, xd;
      logic [2:0] oi;
      logic [31:0] oh, oc, os;
      if (d == 0) begin
        od = done0; op = pass0; ot = to0; ob = busy0; oi = hidx0; oh = hcyc0; oc = cyc0; os = st0;
      end else begin
        od = done1; op = pass1; ot = to1; ob = busy1; oi = hidx1; oh = hcyc1; oc = cyc1; os = st1;
      end
      xd = (m_fin[d] >= 0) && (e > m_fin[d]);
      chk("done",        d, 64'(od), 64'(xd));
      chk("pass",        d, 64'(op), 64'(xd && m_hit[d]));
      chk("timeout",     d, 64'(ot), 64'(m_to[d]));
      chk("busy",        d, 64'(ob), 64'(!xd));
      chk("hit_idx",     d, 64'(oi), 64'(m_hidx[d]));
      chk("hit_cycle",   d, 64'(oh), 64'(m_hcyc[d]));
      chk("cycle_count", d, 64'(oc), 64'(m_cyc[d]));
      chk("store_count", d, 64'(os), 64'(m_st[d]));
    end
  endtask

  task automatic step(input logic [1:0] mw, input logic [63:0] a, input logic [63:0] dat);
    bus.memwrite = mw; bus.dataadr = a; bus.writedata = dat;
    @(posedge clk);
    model_edge(mw, a, dat);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    repeat (n) step(2'b00, {$urandom, $urandom}, {$urandom, $urandom});
  endtask

  task automatic rnd_step();
    step(2'($urandom_range(0, 3)), {$urandom, $urandom}, {$urandom, $urandom});
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    bus.memwrite = '0; bus.dataadr = '0; bus.writedata = '0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic randomize_table();
    for (int i = 0; i < 5; i++) begin
      sa[i] = {$urandom, $urandom};
      sd[i] = {$urandom, $urandom};
    end
  endtask

  // Three stores: (96,3) at cycle 10, (100,5) at cycle 20, hit store (100,hd) at cycle 40.
  task automatic pass_run(input logic [63:0] hd);
    for (int c = 0; c < 41; c++) begin
      if (c == 10)      step(2'b01, 64'd96, 64'd3);
      else if (c == 20) step(2'b10, 64'd100, 64'd5);
      else if (c == 40) step(2'($urandom_range(1, 3)), 64'd100, hd);
      else              idle(1);
    end
    chk("t1_hit_idx",   0, 64'(hidx0), 64'd0);
    chk("t1_hit_cycle", 0, 64'(hcyc0), 64'd40);
    chk("t1_drain0_done_on_hit", 1, 64'(done1), 64'd1);
    idle(9);
    chk("t1_not_done_yet", 0, 64'(done0), 64'd0);
    idle(1);
    chk("t1_done",        0, 64'(done0), 64'd1);
    chk("t1_pass",        0, 64'(pass0), 64'd1);
    chk("t1_store_count", 0, 64'(st0),   64'd3);
    idle(5);
    chk("t1_cycle_frozen", 0, 64'(cyc0), 64'd51);
  endtask

  initial begin
    drain_v[0] = 10;
    drain_v[1] = 0;
    randomize_table();
    en = '0;
    bus.memwrite = '0; bus.dataadr = '0; bus.writedata = '0;

    // Standard pass
    do_reset();
    randomize_table();
    sa[0] = 64'd100; sd[0] = 64'd7; en = 5'b00001;
    pass_run(64'd7);

    // Priority: slots 1 and 3 share a signature; slot 0 has it too but is disabled.
    // Stores matching slot 4 during the drain window are counted, not matched.
    do_reset();
    randomize_table();
    sa[0] = 64'd508; sd[0] = 64'd7;
    sa[1] = 64'd508; sd[1] = 64'd7;
    sa[3] = 64'd508; sd[3] = 64'd7;
    sa[4] = 64'd700; sd[4] = 64'd9;
    en = 5'b11010;
    repeat ($urandom_range(3, 20)) rnd_step();
    step(2'b01, 64'd508, 64'd7);
    chk("t2_hit_idx", 0, 64'(hidx0), 64'd1);
    chk("t2_hit_idx", 1, 64'(hidx1), 64'd1);
    repeat (4) step(2'b11, 64'd700, 64'd9);
    chk("t5_hit_idx_kept", 0, 64'(hidx0), 64'd1);
    idle(10);

    // Disabled slot and timeout
    do_reset();
    randomize_table();
    sa[0] = 64'd80; sd[0] = 64'd1; en = 5'b00000;
    for (int c = 0; c < c_to + 5; c++) begin
      if (c == 5) step(2'b01, 64'd80, 64'd1);
      else        rnd_step();
    end
    chk("t3_timeout", 0, 64'(to0),   64'd1);
    chk("t3_pass",    0, 64'(pass0), 64'd0);
    chk("t3_cycles",  0, 64'(cyc0),  64'd1580);
    chk("t3_cycles",  1, 64'(cyc1),  64'd1580);

    // Hit on the timeout edge wins
    do_reset();
    randomize_table();
    sa[2] = 64'd320; sd[2] = 64'd4950; en = 5'b00100;
    repeat (c_to - 1) rnd_step();
    step(2'b01, 64'd320, 64'd4950);
    chk("t4_busy_drain", 0, 64'(busy0), 64'd1);
    idle(12);
    chk("t4_timeout",   0, 64'(to0),   64'd0);
    chk("t4_pass",      0, 64'(pass0), 64'd1);
    chk("t4_timeout",   1, 64'(to1),   64'd0);
    chk("t4_pass",      1, 64'(pass1), 64'd1);
    chk("t4_hit_cycle", 0, 64'(hcyc0), 64'd1579);

    // Asynchronous reset mid-drain, then a fresh pass run
    do_reset();
    randomize_table();
    sa[0] = 64'd100; sd[0] = 64'd6; en = 5'b00001;
    idle(30);
    step(2'b01, 64'd100, 64'd6);
    idle(3);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("t6_busy_in_reset", 0, 64'(busy0), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    pass_run(64'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sim_result_monitor.md
Name: sim_result_monitor

Overview:
Synthesisable, parametrised pass/fail monitor for the MIPS core's data-memory write port.
- Watches every store and matches it against a table of NUM_SIG programmable (address, data) pass signatures.
- Counts cycles and stores, enforces a timeout watchdog, and holds a drain window after a hit before declaring completion.
- Sits beside `top` in benches and FPGA builds, driven from the same memwrite/dataadr/writedata bus.

Parameters:
- ADDR_W, 64, width of dataadr and of each signature address.
- DATA_W, 64, width of writedata and of each signature data word.
- NUM_SIG, 5, number of signature slots.
- CNT_W, 32, width of the cycle and store counters.
- TIMEOUT, 1580, cycle count at which the run fails if no signature has hit.
- DRAIN, 10, cycles spent in DRAIN after a hit before done asserts.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- memwrite  in  2  store strobe; any non-zero value is a store.
- dataadr  in  ADDR_W  store address.
- writedata  in  DATA_W  store data.
- sig_adr  in  NUM_SIG*ADDR_W  signature addresses, flat; slot i occupies [i*ADDR_W +: ADDR_W].
- sig_data  in  NUM_SIG*DATA_W  signature data, flat, same packing.
- sig_en  in  NUM_SIG  per-slot enable.
- done  out  1  run finished (pass or timeout); sticky.
- pass  out  1  a signature hit; valid only while done=1.
- timeout  out  1  watchdog expired with no hit; sticky.
- hit_idx  out  $clog2(NUM_SIG) (min 1)  index of the slot that hit.
- hit_cycle  out  CNT_W  cycle_count value at the hit.
- cycle_count  out  CNT_W  cycles since reset release.
- store_count  out  CNT_W  stores observed.
- busy  out  1  high in RUN and DRAIN.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=RUN.
  - done, pass, timeout, hit_idx, hit_cycle, cycle_count, store_count all 0.
  - busy=1; drain counter 0.
- States: RUN -> DRAIN -> DONE, or RUN -> DONE on timeout. DONE is terminal until reset.
- cycle_count: increments every clk in RUN and DRAIN; frozen in DONE; saturates at all-ones.
- store_count: increments on each clk with memwrite!=0 in RUN and DRAIN; frozen in DONE; saturates.
- Matching in RUN:
  - Slot i matches when sig_en[i]=1, memwrite!=0, dataadr==sig_adr[i] and writedata==sig_data[i]. Comparison is full width, with no X-propagation reliance.
  - If several slots match, the lowest index wins.
  - On a match at edge T: hit_idx and hit_cycle (the pre-increment cycle_count) latch at T. state=DRAIN and the drain counter is loaded with DRAIN; both are visible after T.
- DRAIN:
  - The drain counter decrements each cycle; stores are counted but not matched.
  - When the counter reaches 1: done=1, pass=1, state=DONE on that edge.
  - DRAIN=0 goes directly RUN -> DONE on the hit edge with pass=1.
- Timeout:
  - In RUN with no match, if cycle_count==TIMEOUT-1 at an edge: timeout=1, done=1, pass=0, state=DONE.
  - A match on that same edge takes priority: it enters DRAIN and timeout stays 0.
  - Timeout is never evaluated in DRAIN.
- sig_* inputs are sampled live every cycle; changing them mid-run affects only subsequent stores.
- busy = (state != DONE).
- Reset asserted mid-DRAIN or in DONE clears everything immediately (asynchronously); the run restarts on release.
- No outputs are combinational from inputs; all are registered.

Decomposition:
- Shared package `monitor_pkg`:
  - state enum {RUN, DRAIN, DONE}.
  - function `sig_slot(flat, i)` for slot extraction.
  - default TIMEOUT and DRAIN constants.
- One sub-module `sig_match_pri`:
  - Combinational NUM_SIG-way comparator plus lowest-index priority encoder.
  - Outputs any_hit and hit_idx.
- Counters and the FSM stay in the top module.

Test Plan:
1. Standard pass:
   - Setup: slot0=(100,7) enabled; stores (96,3), (100,5), then (100,7) at cycle 40.
   - Required: hit_idx=0, hit_cycle=40, done=1 and pass=1 exactly 10 cycles later, store_count=3.
2. Priority:
   - Setup: slots 1 and 3 both (508,7) enabled; store (508,7).
   - Required: hit_idx=1.
3. Disabled slot and timeout:
   - Setup: slot0=(80,1) with sig_en[0]=0; store (80,1); no other hits.
   - Required: at cycle_count reaching 1580, timeout=1, done=1, pass=0; counters then frozen.
4. Timeout collision:
   - Setup: store (320,4950) matching slot2 on the edge where cycle_count==1579.
   - Required: DRAIN entered, timeout stays 0, pass=1 after the drain window.
5. DRAIN behaviour:
   - Setup: after a hit, issue stores matching another slot during the drain window.
   - Required: store_count increments; hit_idx is unchanged.
   - Setup: DRAIN=0.
   - Required: done asserts on the hit edge.
6. Async reset:
   - Setup: pull reset low mid-DRAIN, between clock edges.
   - Required: all outputs 0 and busy=1 immediately; after release, the cycle_count restart and a subsequent (100,6) hit behave as in scenario 1.
